// File: rtl/mem_dmem_access_ctrl.sv
// MEM-stage data-memory access controller: turns load/store requests into a
// req/ack DMEM transaction, formats byte lanes and extends load data.
//
// state | meaning
// IDLE  | waiting for a valid load/store in MEM
// BUSY  | dmem_req high, waiting for ack or timeout
// ERRW  | misaligned/illegal op, one cycle without any request
// DONE  | done pulse; stall released so the pipeline advances
module mem_dmem_access_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        mem_stall,
  output logic        addr_err,
  output logic        timeout_err
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ERRW = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   ld_q, ld_d;
  logic          aerr_q, aerr_d;
  logic          terr_q, terr_d;
  logic          rd_q, rd_d;
  logic          uns_q, uns_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    alo_q, alo_d;

  logic          start;
  logic          bad;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  assign start = (state_q == S_IDLE) & mem_valid & (mem_rd | mem_wr);
  assign bad   = (mem_rd & mem_wr) | (mem_size == 2'b11)
               | ((mem_size == 2'b01) & mem_addr[0])
               | ((mem_size == 2'b10) & (mem_addr[1:0] != 2'b00));

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = mem_wdata;
    case (mem_size)
      2'b00: begin
        st_be    = 4'b0001 << mem_addr[1:0];
        st_wdata = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{mem_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = mem_wdata;
      end
    endcase
  end

  // Lane selection uses the address captured at request time, not the live input.
  always_comb begin
    ld_byte = dmem_rdata[{alo_q, 3'b000} +: 8];
    ld_half = alo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ld_d    = ld_q;
    aerr_d  = 1'b0;
    terr_d  = 1'b0;
    rd_d    = rd_q;
    uns_d   = uns_q;
    size_d  = size_q;
    alo_d   = alo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad) begin
            state_d = S_ERRW;
          end else begin
            state_d = S_BUSY;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = mem_wr;
            addr_d  = {mem_addr[31:2], 2'b00};
            wdata_d = mem_wr ? st_wdata : 32'd0;
            be_d    = mem_wr ? st_be : 4'b1111;
            rd_d    = mem_rd;
            uns_d   = mem_unsigned;
            size_d  = mem_size;
            alo_d   = mem_addr[1:0];
          end
        end
      end
      S_BUSY: begin
        if (dmem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (rd_q) ld_d = ld_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          terr_d  = 1'b1;
          ld_d    = 32'hffff_ffff;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ERRW: begin
        state_d = S_DONE;
        aerr_d  = 1'b1;
        ld_d    = 32'd0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      ld_q    <= 32'd0;
      aerr_q  <= 1'b0;
      terr_q  <= 1'b0;
      rd_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      alo_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ld_q    <= ld_d;
      aerr_q  <= aerr_d;
      terr_q  <= terr_d;
      rd_q    <= rd_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      alo_q   <= alo_d;
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_be     = be_q;
  assign load_data   = ld_q;
  assign done        = (state_q == S_DONE);
  assign addr_err    = aerr_q;
  assign timeout_err = terr_q;
  assign mem_stall   = start | (state_q == S_BUSY) | (state_q == S_ERRW);

endmodule

// File: tb/tb_mem_dmem_access_ctrl.sv
// Directed-vector bench for mem_dmem_access_ctrl with a simple DMEM responder.
module tb_mem_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_rd, mem_wr, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
  logic [3:0]  dmem_be;
  logic        done, mem_stall, addr_err, timeout_err;

  int checks = 0;
  int failures = 0;

  int          r_stall, r_req, r_done_idx;
  logic [31:0] r_ld, r_addr, r_wdata;
  logic        r_aerr, r_terr, r_we, r_after;
  logic [3:0]  r_be;

  always #5 clk = ~clk;

  mem_dmem_access_ctrl #(.MAX_WAIT(16)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .load_data(load_data), .done(done), .mem_stall(mem_stall),
    .addr_err(addr_err), .timeout_err(timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ack_lat: ack on the Nth cycle dmem_req is high; 0 means never ack
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input int ack_lat, input logic [31:0] rdata);
    r_stall = 0; r_req = 0; r_done_idx = -1;
    r_ld = 'x; r_aerr = 1'bx; r_terr = 1'bx;
    r_be = 4'd0; r_we = 1'b0; r_addr = 32'd0; r_wdata = 32'd0;
    @(negedge clk);
    mem_valid = 1'b1; mem_rd = rd; mem_wr = wr; mem_size = sz;
    mem_unsigned = uns; mem_addr = addr; mem_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      #1;
      dmem_ack = 1'b0;
      if (mem_stall) r_stall++;
      if (done) begin
        r_done_idx = i;
        r_ld = load_data; r_aerr = addr_err; r_terr = timeout_err;
        mem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        break;
      end
      if (dmem_req) begin
        r_req++;
        r_be = dmem_be; r_we = dmem_we; r_addr = dmem_addr; r_wdata = dmem_wdata;
        if (ack_lat > 0 && r_req == ack_lat) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
        end
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    mem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    if (r_done_idx < 0) check_eq("done_within_bound", 32'd0, 32'd1);
    @(negedge clk);
    #1;
    r_after = done | addr_err | timeout_err | mem_stall | dmem_req;
  endtask

  initial begin
    reset = 1'b1; mem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_size = 2'b10; mem_unsigned = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_outputs",
             {dmem_req, dmem_we, done, mem_stall, addr_err, timeout_err, dmem_be}, 32'd0);
    check_eq("rst_addr", dmem_addr | dmem_wdata, 32'd0);
    check_eq("rst_ld", load_data, 32'd0);
    reset = 1'b0;

    run_op(1, 0, 2'b10, 0, 32'h100, 0, 1, 32'hDEADBEEF);
    check_eq("lw_ld", r_ld, 32'hDEADBEEF);
    check_eq("lw_stall", r_stall, 2);
    check_eq("lw_done_idx", r_done_idx, 2);
    check_eq("lw_req", r_req, 1);
    check_eq("lw_bus", {r_we, r_be}, 5'b0_1111);
    check_eq("lw_addr", r_addr, 32'h100);
    check_eq("lw_err", {r_aerr, r_terr}, 2'b00);
    check_eq("lw_after", r_after, 0);

    run_op(1, 0, 2'b00, 0, 32'h103, 0, 1, 32'h80FFFF12);
    check_eq("lb_ld", r_ld, 32'hFFFFFF80);
    check_eq("lb_addr", r_addr, 32'h100);
    run_op(1, 0, 2'b00, 1, 32'h103, 0, 1, 32'h80FFFF12);
    check_eq("lbu_ld", r_ld, 32'h00000080);
    run_op(1, 0, 2'b01, 0, 32'h102, 0, 1, 32'h80FFFF12);
    check_eq("lh_ld", r_ld, 32'hFFFF80FF);

    run_op(1, 0, 2'b01, 1, 32'h100, 0, 3, 32'h1234F00D);
    check_eq("lhu_ld", r_ld, 32'h0000F00D);
    check_eq("lhu_req", r_req, 3);
    check_eq("lhu_stall", r_stall, 4);
    check_eq("lhu_done_idx", r_done_idx, 4);

    run_op(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 1, 32'd0);
    check_eq("sh_bus", {r_we, r_be}, 5'b1_1100);
    check_eq("sh_wdata", r_wdata, 32'hABCDABCD);
    check_eq("sh_addr", r_addr, 32'h200);
    check_eq("sh_ld_held", r_ld, 32'h0000F00D);

    run_op(0, 1, 2'b00, 0, 32'h201, 32'h12345677, 2, 32'd0);
    check_eq("sb_bus", {r_we, r_be}, 5'b1_0010);
    check_eq("sb_wdata", r_wdata, 32'h77777777);

    run_op(0, 1, 2'b10, 0, 32'h204, 32'hCAFEF00D, 1, 32'd0);
    check_eq("sw_bus", {r_we, r_be}, 5'b1_1111);
    check_eq("sw_wdata", r_wdata, 32'hCAFEF00D);
    check_eq("sw_addr", r_addr, 32'h204);

    run_op(1, 0, 2'b10, 0, 32'h101, 0, 1, 32'h11111111);
    check_eq("mis_req", r_req, 0);
    check_eq("mis_err", {r_aerr, r_terr}, 2'b10);
    check_eq("mis_ld", r_ld, 32'd0);
    check_eq("mis_done_idx", r_done_idx, 2);
    check_eq("mis_after", r_after, 0);

    run_op(1, 1, 2'b10, 0, 32'h200, 0, 1, 32'h11111111);
    check_eq("rdwr_req", r_req, 0);
    check_eq("rdwr_err", {r_aerr, r_terr}, 2'b10);
    run_op(1, 0, 2'b11, 0, 32'h0, 0, 1, 32'h11111111);
    check_eq("sz11_err", {r_aerr, r_terr}, 2'b10);
    run_op(0, 1, 2'b01, 0, 32'h201, 32'h5555, 1, 32'd0);
    check_eq("sh_mis_req", r_req, 0);
    check_eq("sh_mis_err", {r_aerr, r_terr}, 2'b10);

    run_op(1, 0, 2'b10, 0, 32'h300, 0, 0, 32'd0);
    check_eq("to_req", r_req, 16);
    check_eq("to_err", {r_aerr, r_terr}, 2'b01);
    check_eq("to_ld", r_ld, 32'hFFFFFFFF);
    check_eq("to_done_idx", r_done_idx, 17);
    check_eq("to_after", r_after, 0);

    @(negedge clk);
    mem_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; mem_size = 2'b10; mem_addr = 32'h100;
    @(negedge clk);
    #1;
    check_eq("rst_mid_req_before", dmem_req, 1);
    reset = 1'b1; mem_valid = 1'b0; mem_rd = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_mid_outs", {dmem_req, mem_stall, done, addr_err, timeout_err}, 5'd0);
    check_eq("rst_mid_ld", load_data, 32'd0);
    reset = 1'b0;
    run_op(1, 0, 2'b10, 0, 32'h100, 0, 1, 32'h0BADF00D);
    check_eq("post_rst_ld", r_ld, 32'h0BADF00D);
    check_eq("post_rst_done_idx", r_done_idx, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
